// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
//
// Bulk-copy engine that streams a block of words from the HD memory
// (synchronous read port, one-cycle read latency) into the instruction RAM
// write port at one word per cycle. It is used to load a program image before
// the processor starts fetching.
//
// Handshake: `start` is a request strobe. It is sampled only while the engine
// is idle. A start seen in any other state is dropped, not queued. The request
// operands (src_base, dst_base, word_count) are captured on the accepting
// edge, so they may change freely afterwards. Completion is reported by a
// one-cycle `done` pulse. `error` pulses together with `done` when the
// request was rejected for range.
//
// Ports
//   clock                 : single clock, rising edge
//   reset                 : asynchronous, active-high reset
//   start                 : copy request (sampled in IDLE only)
//   src_base              : first HD word address
//   dst_base              : first instruction RAM address
//   word_count            : words to copy, 0 .. 2^IADDR_WIDTH
//   hd_read_address       : registered HD read address
//   hd_read_data          : HD read data, valid the cycle after its address
//   i_ram_writing_address : registered instruction RAM write address
//   i_ram_input           : write data (pass-through of hd_read_data)
//   flag_write_i_ram      : write strobe, one word per high cycle
//   busy                  : copy in progress (COPY or DRAIN)
//   done                  : one-cycle completion pulse
//   error                 : one-cycle range-error pulse, coincident with done
//   checksum              : running sum of written words (optional)
//
// Build option
//   INSTRUCTION_LOADER_CHECKSUM_EN : when defined, `checksum` accumulates
//   every written word modulo 2^DATA_WIDTH. It is cleared on each accepted
//   start. When undefined, no accumulator exists and `checksum` is tied to 0.
// ---------------------------------------------------------------------------
module instruction_loader #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned IADDR_WIDTH   = 10,
    parameter int unsigned HD_ADDR_WIDTH = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [HD_ADDR_WIDTH-1:0] src_base,
    input  logic [IADDR_WIDTH-1:0]   dst_base,
    input  logic [IADDR_WIDTH:0]     word_count,
    output logic [HD_ADDR_WIDTH-1:0] hd_read_address,
    input  logic [DATA_WIDTH-1:0]    hd_read_data,
    output logic [IADDR_WIDTH-1:0]   i_ram_writing_address,
    output logic [DATA_WIDTH-1:0]    i_ram_input,
    output logic                     flag_write_i_ram,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [DATA_WIDTH-1:0]    checksum
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    // Instruction RAM depth, expressed at IADDR_WIDTH+2 bits so that the
    // range sum dst_base + word_count can never overflow.
    localparam logic [IADDR_WIDTH+1:0]   RAM_DEPTH = {2'b01, {IADDR_WIDTH{1'b0}}};
    localparam logic [IADDR_WIDTH:0]     CNT_ONE   = (IADDR_WIDTH+1)'(1);
    localparam logic [IADDR_WIDTH-1:0]   WADDR_ONE = IADDR_WIDTH'(1);
    localparam logic [HD_ADDR_WIDTH-1:0] RADDR_ONE = HD_ADDR_WIDTH'(1);

    // -----------------------------------------------------------------------
    // FSM state
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COPY   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    // Reads still to issue after the address currently on hd_read_address.
    // When it reaches zero in COPY, the last read is on the bus.
    logic [IADDR_WIDTH:0]   remaining_q;
    // Destination address of the word whose read is currently on the bus.
    // It is handed to i_ram_writing_address one cycle later, when the data
    // returns from the HD memory.
    logic [IADDR_WIDTH-1:0] wr_ptr_q;
    // Set when the latched request failed the range check.
    logic                   err_q;

    // -----------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // -----------------------------------------------------------------------
    logic [IADDR_WIDTH+1:0] range_end;
    logic                   zero_count;
    logic                   range_err;
    logic                   accept;

    assign range_end  = {2'b00, dst_base} + {1'b0, word_count};
    assign zero_count = (word_count == '0);
    assign range_err  = (range_end > RAM_DEPTH);
    assign accept     = (state_q == S_IDLE) && start;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Empty or out-of-range requests skip straight to the
                    // completion pulse without touching either memory.
                    if (zero_count || range_err) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_COPY;
                    end
                end
            end
            S_COPY: begin
                if (remaining_q == '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs decoded from state
    // -----------------------------------------------------------------------
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        error = 1'b0;
        case (state_q)
            S_COPY, S_DRAIN: begin
                busy = 1'b1;
            end
            S_FINISH: begin
                done  = 1'b1;
                error = err_q;
            end
            default: begin
                busy  = 1'b0;
                done  = 1'b0;
                error = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Read/write address generation and write strobe
    // -----------------------------------------------------------------------
    // The HD port returns data one cycle after the address, so the write
    // side is the read side delayed by one cycle: every COPY cycle issues a
    // read, and the following cycle writes its data. DRAIN exists only to
    // write the data of the final read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hd_read_address       <= '0;
            i_ram_writing_address <= '0;
            flag_write_i_ram      <= 1'b0;
            remaining_q           <= '0;
            wr_ptr_q              <= '0;
            err_q                 <= 1'b0;
        end else begin
            flag_write_i_ram <= (state_q == S_COPY);

            if (accept) begin
                err_q <= range_err;
                if (!zero_count && !range_err) begin
                    hd_read_address <= src_base;
                    remaining_q     <= word_count - CNT_ONE;
                    wr_ptr_q        <= dst_base;
                end
            end

            if (state_q == S_COPY) begin
                i_ram_writing_address <= wr_ptr_q;
                // The pointer may step past the top of the RAM after the last
                // word. That value is never used for a write.
                wr_ptr_q <= wr_ptr_q + WADDR_ONE;
                if (remaining_q != '0) begin
                    // HD addressing wraps naturally at 2^HD_ADDR_WIDTH.
                    hd_read_address <= hd_read_address + RADDR_ONE;
                    remaining_q     <= remaining_q - CNT_ONE;
                end
            end
        end
    end

    // Write data is the HD read data itself. It is only meaningful while the
    // strobe is high.
    assign i_ram_input = hd_read_data;

    // -----------------------------------------------------------------------
    // Optional checksum accumulator
    // -----------------------------------------------------------------------
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    // The last word is added on the edge that ends DRAIN. The sum is
    // therefore final in the done cycle and holds until the next accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= '0;
        end else if (flag_write_i_ram) begin
            checksum_q <= checksum_q + hd_read_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    // -----------------------------------------------------------------------
    // Structural invariants
    // -----------------------------------------------------------------------
`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (!reset) begin
            // A write can only happen while a copy is in flight.
            assert (!flag_write_i_ram || busy);
            // Completion and activity are mutually exclusive.
            assert (!(done && busy));
            // Error is only ever reported alongside done.
            assert (!error || done);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int HW = 12;

    // ---------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ---------------------------------------------------------------------
    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [HW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW:0]   word_count = '0;
    logic [HW-1:0] hd_read_address;
    logic [DW-1:0] hd_read_data = '0;
    logic [AW-1:0] i_ram_writing_address;
    logic [DW-1:0] i_ram_input;
    logic          flag_write_i_ram;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] checksum;

    always #5 clock = ~clock;

    instruction_loader #(
        .DATA_WIDTH   (DW),
        .IADDR_WIDTH  (AW),
        .HD_ADDR_WIDTH(HW)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .start                (start),
        .src_base             (src_base),
        .dst_base             (dst_base),
        .word_count           (word_count),
        .hd_read_address      (hd_read_address),
        .hd_read_data         (hd_read_data),
        .i_ram_writing_address(i_ram_writing_address),
        .i_ram_input          (i_ram_input),
        .flag_write_i_ram     (flag_write_i_ram),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .checksum             (checksum)
    );

    // ---------------------------------------------------------------------
    // HD memory model: synchronous read, one-cycle latency
    // ---------------------------------------------------------------------
    logic [DW-1:0] hd_mem [0:(1<<HW)-1];

    always @(posedge clock) hd_read_data <= hd_mem[hd_read_address];

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard of expected writes: {address, data}
    logic [AW+DW-1:0] exp_q[$];

    always @(negedge clock) begin
        if (!reset && flag_write_i_ram === 1'b1) begin
            check_eq("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                check_eq("write_addr", 64'(i_ram_writing_address), 64'(e[AW+DW-1:DW]));
                check_eq("write_data", 64'(i_ram_input), 64'(e[DW-1:0]));
            end
        end
    end

    function automatic logic [DW-1:0] exp_checksum(input logic [DW-1:0] sum);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        return sum;
`else
        return (sum & '0);
`endif
    endfunction

    // ---------------------------------------------------------------------
    // Driver: one copy request, checked cycle by cycle. Returns at the
    // negedge of the first IDLE cycle after done.
    // ---------------------------------------------------------------------
    task automatic run_copy(input logic [HW-1:0] src, input logic [AW-1:0] dst,
                            input logic [AW:0] cnt, input bit glitch_mid, input bit glitch_done);
        int            n;
        bit            is_err;
        logic [DW-1:0] sum;
        logic [HW-1:0] ra;
        logic [AW-1:0] wa;
        n      = int'(cnt);
        is_err = (int'(dst) + n) > (1 << AW);
        sum    = '0;
        if (!is_err && n != 0) begin
            for (int i = 0; i < n; i++) begin
                ra = src + HW'(i);
                wa = dst + AW'(i);
                exp_q.push_back({wa, hd_mem[ra]});
                sum = sum + hd_mem[ra];
            end
        end

        src_base   = src;
        dst_base   = dst;
        word_count = cnt;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;

        if (is_err || n == 0) begin
            check_eq("short_busy", 64'(busy), 64'd0);
            check_eq("short_done", 64'(done), 64'd1);
            check_eq("short_error", 64'(error), 64'(is_err));
            check_eq("short_strobe", 64'(flag_write_i_ram), 64'd0);
            check_eq("short_checksum", 64'(checksum), 64'(exp_checksum('0)));
        end else begin
            for (int k = 1; k <= n + 2; k++) begin
                if (k > 1) @(negedge clock);
                check_eq("busy", 64'(busy), 64'(k <= n + 1));
                check_eq("done", 64'(done), 64'(k == n + 2));
                check_eq("error", 64'(error), 64'd0);
                if (k <= n) begin
                    ra = src + HW'(k - 1);
                    check_eq("read_addr", 64'(hd_read_address), 64'(ra));
                end
                if (glitch_mid && k == 3) begin
                    start      = 1'b1;
                    src_base   = ~src;
                    dst_base   = '0;
                    word_count = 11'd1;
                end
                if (glitch_mid && k == 4) start = 1'b0;
            end
            check_eq("checksum", 64'(checksum), 64'(exp_checksum(sum)));
        end
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

        if (glitch_done) begin
            start      = 1'b1;
            src_base   = 12'h000;
            dst_base   = 10'd0;
            word_count = 11'd2;
        end
        @(negedge clock);
        start = 1'b0;
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("idle_done", 64'(done), 64'd0);
        check_eq("idle_error", 64'(error), 64'd0);
    endtask

    // Reset asserted in the third write cycle of a 10-word copy.
    task automatic reset_mid_copy();
        logic [HW-1:0] src;
        logic [AW-1:0] dst;
        src = 12'h100;
        dst = 10'h040;
        for (int i = 0; i < 2; i++) exp_q.push_back({dst + AW'(i), hd_mem[src + HW'(i)]});
        src_base   = src;
        dst_base   = dst;
        word_count = 11'd10;
        start      = 1'b1;
        @(negedge clock);           // T+1
        start = 1'b0;
        @(negedge clock);           // T+2, first write
        @(negedge clock);           // T+3, second write
        @(posedge clock);           // start of T+4, third write cycle
        #2 reset = 1'b1;
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_strobe", 64'(flag_write_i_ram), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        check_eq("rst_rd_addr", 64'(hd_read_address), 64'd0);
        check_eq("rst_wr_addr", 64'(i_ram_writing_address), 64'd0);
        check_eq("rst_checksum", 64'(checksum), 64'd0);
        @(negedge clock);
        check_eq("rst_partial_writes", 64'(exp_q.size()), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            check_eq("post_rst_done", 64'(done), 64'd0);
            check_eq("post_rst_busy", 64'(busy), 64'd0);
        end
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin
        for (int i = 0; i < (1 << HW); i++) hd_mem[i] = $urandom;
        hd_mem[12'h010] = 32'hA000_0001;
        hd_mem[12'h011] = 32'hB000_0002;
        hd_mem[12'h012] = 32'hC000_0003;
        hd_mem[12'h013] = 32'hD000_0004;

        repeat (2) @(negedge clock);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_error", 64'(error), 64'd0);
        check_eq("reset_strobe", 64'(flag_write_i_ram), 64'd0);
        check_eq("reset_rd_addr", 64'(hd_read_address), 64'd0);
        check_eq("reset_wr_addr", 64'(i_ram_writing_address), 64'd0);
        check_eq("reset_checksum", 64'(checksum), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        run_copy(12'h010, 10'd5,    11'd4, 1'b0, 1'b0);  // A..D to 5..8
        run_copy(12'h123, 10'd5,    11'd0, 1'b0, 1'b0);  // zero count
        run_copy(12'h200, 10'd1020, 11'd5, 1'b0, 1'b0);  // range error
        run_copy(12'h300, 10'd1019, 11'd5, 1'b0, 1'b0);  // ends exactly at 1023
        run_copy(12'hFFE, 10'd100,  11'd3, 1'b0, 1'b0);  // HD address wrap
        run_copy(12'h020, 10'd10,   11'd8, 1'b1, 1'b1);  // ignored start pulses
        run_copy(12'h040, 10'd30,   11'd3, 1'b0, 1'b0);  // start right after done
        reset_mid_copy();
        run_copy(12'h100, 10'h040, 11'd10, 1'b0, 1'b0);
        run_copy(12'h000, 10'd0, 11'd1024, 1'b0, 1'b0);  // full RAM
        run_copy(12'h000, 10'd1, 11'd1024, 1'b0, 1'b0);  // one past full
        for (int r = 0; r < 6; r++) begin
            run_copy(HW'($urandom_range(0, (1 << HW) - 1)),
                     AW'($urandom_range(1000, 1023)),
                     (AW+1)'($urandom_range(1, 30)), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
